// File: rtl/video_pkg.sv
// Shared video timing defaults, FSM state type and Wishbone cycle constants
// for the SDRAM frame reader.
package video_pkg;

   localparam int HDISP_DEF = 800;
   localparam int VDISP_DEF = 480;
   localparam int NPIX_DEF  = HDISP_DEF * VDISP_DEF;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      PAUSE
   } state_t;

   localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
   localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wshb_frame_reader_if.sv
// Wishbone classic bus bundle between the frame reader (master) and the
// SDRAM slave port.
interface wshb_if;

   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [31:0] dat_ms;
   logic [31:0] dat_sm;
   logic        ack;
   logic        err;
   logic        rty;

   modport master (
      output cyc, stb, we, adr, sel, cti, bte, dat_ms,
      input  dat_sm, ack, err, rty
   );

   modport slave (
      input  cyc, stb, we, adr, sel, cti, bte, dat_ms,
      output dat_sm, ack, err, rty
   );

endinterface

// File: rtl/wshb_frame_reader.sv
// Wishbone master that streams one frame of 32-bit pixels from SDRAM into the
// video FIFO per frame_start pulse, pausing whenever the FIFO is almost full.
module wshb_frame_reader
   import video_pkg::*;
#(
   parameter int          HDISP     = HDISP_DEF,
   parameter int          VDISP     = VDISP_DEF,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        frame_start,
   wshb_if.master      wb,
   output logic [31:0] fifo_wdata,
   output logic        fifo_write,
   input  logic        fifo_walmost_full,
   output logic        frame_busy,
   output logic        overrun
);

   localparam int NPIX = HDISP * VDISP;
   localparam int CW   = $clog2(NPIX + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);

   state_t        state;
   state_t        next_state;
   logic [CW-1:0] count;
   logic [31:0]   adr;

   logic in_read;
   logic accept;
   logic advance;
   logic retry;
   logic last_word;

   assign in_read   = (state == READ);
   assign accept    = (state == IDLE) && frame_start;
   assign advance   = in_read && (wb.ack || wb.err);
   assign retry     = in_read && wb.rty && !wb.ack && !wb.err;
   assign last_word = advance && (count == LAST_IDX);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               next_state = fifo_walmost_full ? PAUSE : READ;
            end
         end
         READ: begin
            if (last_word) begin
               next_state = IDLE;
            end else if (advance) begin
               next_state = fifo_walmost_full ? PAUSE : READ;
            end else if (retry) begin
               next_state = READ;
            end
         end
         PAUSE: begin
            if (!fifo_walmost_full) begin
               next_state = READ;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // cyc/stb follow the state directly so an async reset drops them at once
   always_comb begin
      wb.cyc    = in_read;
      wb.stb    = in_read;
      wb.we     = 1'b0;
      wb.adr    = adr;
      wb.sel    = 4'hF;
      wb.cti    = WB_CTI_CLASSIC;
      wb.bte    = WB_BTE_LINEAR;
      wb.dat_ms = 32'h0;
   end

   // An errored word is still written (as zero) so the frame stays aligned
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         count      <= '0;
         adr        <= BASE_ADDR;
         fifo_wdata <= 32'h0;
         fifo_write <= 1'b0;
         frame_busy <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         fifo_write <= 1'b0;
         if (frame_start && frame_busy) begin
            overrun <= 1'b1;
         end
         if (accept) begin
            count      <= '0;
            adr        <= BASE_ADDR;
            frame_busy <= 1'b1;
         end
         if (advance) begin
            fifo_write <= 1'b1;
            fifo_wdata <= wb.ack ? wb.dat_sm : 32'h0;
            count      <= count + CW'(1);
            adr        <= adr + 32'd4;
            if (last_word) begin
               frame_busy <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_wshb_frame_reader.sv
// Directed bench for wshb_frame_reader on a 4x2 frame at base 0x100 with a
// behavioural SDRAM slave supporting wait states, err, rty and FIFO backpressure.
module tb_wshb_frame_reader;
   import video_pkg::*;

   localparam logic [31:0] BASE = 32'h100;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        frame_start = 1'b0;
   logic        fifo_walmost_full = 1'b0;
   logic [31:0] fifo_wdata;
   logic        fifo_write;
   logic        frame_busy;
   logic        overrun;

   wshb_if wb ();

   wshb_frame_reader #(
      .HDISP     (4),
      .VDISP     (2),
      .BASE_ADDR (BASE)
   ) dut (
      .sys_clk           (sys_clk),
      .sys_rst           (sys_rst),
      .frame_start       (frame_start),
      .wb                (wb),
      .fifo_wdata        (fifo_wdata),
      .fifo_write        (fifo_write),
      .fifo_walmost_full (fifo_walmost_full),
      .frame_busy        (frame_busy),
      .overrun           (overrun)
   );

   always #5 sys_clk = ~sys_clk;

   int checks   = 0;
   int failures = 0;

   int wait_states = 0;
   int err_idx     = -1;
   int rty_idx     = -1;
   int af_after    = 0;
   bit rty_done    = 0;
   int wait_cnt    = 0;
   int adv_cnt     = 0;
   int af_hold     = 0;

   logic [31:0] wr_q[$];
   logic [31:0] adr_q[$];
   int          stb_cycles   = 0;
   int          pause_cycles = 0;

   function automatic logic [31:0] pattern(int i);
      return 32'hC0DE_0000 + 32'(i) * 32'h11;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Slave drives responses #1 after each edge; also raises almost_full for 10 cycles
   initial begin
      wb.ack    = 1'b0;
      wb.err    = 1'b0;
      wb.rty    = 1'b0;
      wb.dat_sm = 32'h0;
      forever begin
         @(posedge sys_clk);
         #1;
         wb.ack = 1'b0;
         wb.err = 1'b0;
         wb.rty = 1'b0;
         if (af_hold > 0) begin
            af_hold--;
            if (af_hold == 0) fifo_walmost_full = 1'b0;
         end
         if (!sys_rst && wb.stb) begin
            if (wait_cnt < wait_states) begin
               wait_cnt++;
            end else begin
               int idx;
               wait_cnt  = 0;
               idx       = int'((wb.adr - BASE) >> 2);
               wb.dat_sm = pattern(idx);
               if (idx == rty_idx && !rty_done) begin
                  wb.rty   = 1'b1;
                  rty_done = 1'b1;
               end else if (idx == err_idx) begin
                  wb.err = 1'b1;
               end else begin
                  wb.ack = 1'b1;
               end
               if (!wb.rty) begin
                  adv_cnt++;
                  if (adv_cnt == af_after) begin
                     fifo_walmost_full = 1'b1;
                     af_hold           = 10;
                  end
               end
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge sys_clk);
         if (fifo_write) wr_q.push_back(fifo_wdata);
         if (wb.stb && (wb.ack || wb.err || wb.rty)) adr_q.push_back(wb.adr);
         if (wb.stb) stb_cycles++;
         if (frame_busy && !wb.cyc) pause_cycles++;
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus();
      @(negedge sys_clk);
      frame_start = 1'b1;
      @(negedge sys_clk);
      frame_start = 1'b0;
   endtask

   task automatic clearLog();
      wr_q.delete();
      adr_q.delete();
      stb_cycles   = 0;
      pause_cycles = 0;
      adv_cnt      = 0;
      rty_done     = 1'b0;
   endtask

   task automatic waitFrameDone(input string tag);
      int n = 0;
      while (frame_busy && n < 1000) begin
         @(negedge sys_clk);
         n++;
      end
      checkOutput({tag, "_done"}, 32'(n < 1000), 32'd1);
      checkOutput({tag, "_busy_fall_write"}, 32'(fifo_write), 32'd1);
      repeat (3) @(negedge sys_clk);
      checkOutput({tag, "_cyc_idle"}, 32'(wb.cyc), 32'd0);
   endtask

   task automatic checkFrame(input string tag, input int zero_idx);
      checkOutput({tag, "_nwrites"}, 32'(wr_q.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         logic [31:0] obs;
         obs = (i < wr_q.size()) ? wr_q[i] : 32'hDEAD_BEEF;
         checkOutput($sformatf("%s_word%0d", tag, i), obs, (i == zero_idx) ? 32'h0 : pattern(i));
      end
   endtask

   function automatic logic [31:0] adrAt(int i);
      return (i < adr_q.size()) ? adr_q[i] : 32'hDEAD_BEEF;
   endfunction

   initial begin
      logic [31:0] exp4 [9];
      int n;
      exp4 = '{32'h100, 32'h104, 32'h104, 32'h108, 32'h10C,
               32'h110, 32'h114, 32'h118, 32'h11C};

      repeat (3) @(negedge sys_clk);
      checkOutput("rst_cyc", 32'(wb.cyc), 32'd0);
      checkOutput("rst_stb", 32'(wb.stb), 32'd0);
      checkOutput("rst_adr", wb.adr, BASE);
      checkOutput("rst_fifo_write", 32'(fifo_write), 32'd0);
      checkOutput("rst_fifo_wdata", fifo_wdata, 32'h0);
      checkOutput("rst_busy", 32'(frame_busy), 32'd0);
      checkOutput("rst_overrun", 32'(overrun), 32'd0);
      checkOutput("const_we", 32'(wb.we), 32'd0);
      checkOutput("const_sel", 32'(wb.sel), 32'hF);
      checkOutput("const_cti", 32'(wb.cti), 32'd0);
      checkOutput("const_bte", 32'(wb.bte), 32'd0);
      checkOutput("const_dat_ms", wb.dat_ms, 32'h0);
      sys_rst = 1'b0;

      // Test 1: ack every cycle
      clearLog();
      applyStimulus();
      waitFrameDone("t1");
      checkFrame("t1", -1);
      checkOutput("t1_nterm", 32'(adr_q.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("t1_adr%0d", i), adrAt(i), BASE + 32'(4 * i));
      end
      checkOutput("t1_stb_cycles", 32'(stb_cycles), 32'd8);

      // Test 2: two wait states per access
      wait_states = 2;
      clearLog();
      applyStimulus();
      waitFrameDone("t2");
      checkFrame("t2", -1);
      checkOutput("t2_stb_cycles", 32'(stb_cycles), 32'd24);
      wait_states = 0;

      // Test 3: almost_full after the 3rd ack for 10 cycles
      af_after = 3;
      clearLog();
      applyStimulus();
      waitFrameDone("t3");
      checkFrame("t3", -1);
      checkOutput("t3_pause_cycles", 32'(pause_cycles), 32'd10);
      checkOutput("t3_resume_adr", adrAt(3), 32'h10C);
      af_after = 0;

      // Test 4: rty on word 2, err on word 5
      rty_idx = 1;
      err_idx = 4;
      clearLog();
      applyStimulus();
      waitFrameDone("t4");
      checkFrame("t4", 4);
      checkOutput("t4_nterm", 32'(adr_q.size()), 32'd9);
      for (int i = 0; i < 9; i++) begin
         checkOutput($sformatf("t4_adr%0d", i), adrAt(i), exp4[i]);
      end
      rty_idx = -1;
      err_idx = -1;

      // Test 5: frame_start while busy
      clearLog();
      applyStimulus();
      checkOutput("t5_overrun_before", 32'(overrun), 32'd0);
      applyStimulus();
      checkOutput("t5_overrun_set", 32'(overrun), 32'd1);
      waitFrameDone("t5a");
      checkFrame("t5a", -1);
      checkOutput("t5_overrun_sticky", 32'(overrun), 32'd1);
      clearLog();
      applyStimulus();
      waitFrameDone("t5b");
      checkFrame("t5b", -1);
      checkOutput("t5b_first_adr", adrAt(0), BASE);
      checkOutput("t5b_overrun", 32'(overrun), 32'd1);

      // Test 6: reset with the 3rd ack pending
      wait_states = 2;
      clearLog();
      applyStimulus();
      n = 0;
      do begin
         @(posedge sys_clk);
         #2;
         n++;
      end while (!(wb.ack && adv_cnt >= 3) && n < 200);
      checkOutput("t6_ack_seen", 32'(n < 200), 32'd1);
      sys_rst = 1'b1;
      #1;
      checkOutput("t6_cyc", 32'(wb.cyc), 32'd0);
      checkOutput("t6_stb", 32'(wb.stb), 32'd0);
      checkOutput("t6_adr", wb.adr, BASE);
      checkOutput("t6_fifo_write", 32'(fifo_write), 32'd0);
      checkOutput("t6_fifo_wdata", fifo_wdata, 32'h0);
      checkOutput("t6_busy", 32'(frame_busy), 32'd0);
      checkOutput("t6_overrun", 32'(overrun), 32'd0);
      repeat (3) @(negedge sys_clk);
      checkOutput("t6_no_write", 32'(wr_q.size()), 32'd2);
      sys_rst     = 1'b0;
      wait_states = 0;
      clearLog();
      applyStimulus();
      waitFrameDone("t6b");
      checkFrame("t6b", -1);
      checkOutput("t6b_first_adr", adrAt(0), BASE);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/wshb_frame_reader.md
Name: wshb_frame_reader

Overview:
Wishbone master that fetches one video frame per request from SDRAM over the sys_clk Wishbone bus and pushes each 32-bit pixel word into the write side of the video FIFO.
It sits between the SDRAM Wishbone slave port of the hardware support and the pixel-domain display path.
The display path consumes the FIFO in the pixel clock domain and provides the frame-start request, already synchronized to sys_clk.
The block fills the slot of the current tie-offs on the SDRAM Wishbone interface.

Parameters:
HDISP, 800, active pixels per line
VDISP, 480, active lines per frame
BASE_ADDR, 32'h0000_0000, byte address of pixel 0; must be 4-byte aligned

Ports:
sys_clk  in  1  system clock, 100 MHz
sys_rst  in  1  reset, asynchronous, active-high
frame_start  in  1  single-cycle pulse, synchronous to sys_clk: start fetching a new frame
wb_cyc  out  1  Wishbone cycle
wb_stb  out  1  Wishbone strobe
wb_we  out  1  write enable; constant 0
wb_adr  out  32  byte address
wb_sel  out  4  byte select; constant 4'hF
wb_cti  out  3  cycle type; constant 3'b000 (classic)
wb_bte  out  2  burst type; constant 2'b00
wb_dat_ms  out  32  write data; constant 0
wb_dat_sm  in  32  read data
wb_ack  in  1  acknowledge
wb_err  in  1  error termination
wb_rty  in  1  retry termination
fifo_wdata  out  32  pixel word to FIFO
fifo_write  out  1  FIFO write strobe, one word per cycle
fifo_walmost_full  in  1  FIFO has fewer than 4 free slots
frame_busy  out  1  high from frame acceptance until the last word is written
overrun  out  1  sticky: frame_start arrived while busy

Behaviour:
- Derived constant NPIX = HDISP*VDISP. Pixel counter width = $clog2(NPIX+1).
- wb_adr = BASE_ADDR + 4*pixel_index. The index increments only on a terminated read.
- Reset values: state IDLE, wb_cyc=0, wb_stb=0, wb_adr=BASE_ADDR, pixel counter 0, fifo_write=0, fifo_wdata=0, frame_busy=0, overrun=0.
- FSM states IDLE, READ, PAUSE.
- IDLE:
  - On frame_start: pixel counter=0, wb_adr=BASE_ADDR, frame_busy=1.
  - Go to READ if fifo_walmost_full=0, else PAUSE.
- READ:
  - wb_cyc=wb_stb=1. Both are held until a termination (ack, err or rty) is sampled.
  - On wb_ack: fifo_wdata<=wb_dat_sm and fifo_write<=1 (registered, 1-cycle latency after ack); counter++, wb_adr+=4.
  - On wb_err without ack: same as ack, but fifo_wdata<=0. Frame alignment is preserved.
  - On wb_rty without ack/err: no write, no advance; same address reissued next cycle.
  - After an advancing termination:
    - if counter reaches NPIX: deassert cyc/stb next cycle, go IDLE, frame_busy=0 in the same cycle as the last fifo_write;
    - else if fifo_walmost_full=1 (sampled in the termination cycle): deassert cyc/stb, go PAUSE;
    - else stay in READ with stb held continuously (back-to-back, one word per cycle max).
- PAUSE: cyc=stb=0. Return to READ the cycle after fifo_walmost_full is sampled 0.
- fifo_walmost_full never aborts a cycle in progress; the 4-slot margin absorbs the in-flight word.
- frame_start while frame_busy=1: ignored, overrun<=1. overrun clears only on reset.
- frame_start coincident with the last termination: treated as busy; it is ignored and sets overrun.
- Reset mid-cycle: cyc/stb drop asynchronously. Any pending ack is discarded and no FIFO write occurs.
- Counter and address never wrap within a frame. Each new frame restarts at BASE_ADDR.

Decomposition:
- Package video_pkg: HDISP/VDISP defaults, NPIX, the state enum type, and the Wishbone CTI/BTE constants.
- Single module; no sub-module needed.
- The Top instantiates it on wshb_if_sdram (master side) and replaces the tie-offs.

Test Plan:
1. HDISP=4, VDISP=2, BASE_ADDR=32'h100; slave acks every cycle; one frame_start.
   - Expect 8 fifo_write pulses with data equal to the slave pattern.
   - Expect addresses 0x100..0x11C.
   - frame_busy falls with the 8th write; cyc is low afterwards.
2. Slave inserts 2 wait states per access.
   - stb stays high through the waits.
   - Exactly one fifo_write per ack; 8 total.
3. Assert fifo_walmost_full after the 3rd ack for 10 cycles.
   - cyc drops after word 3.
   - Reading resumes at 0x10C one cycle after release.
   - Order is intact.
4. Word 5 terminated by wb_err, word 2 by wb_rty once.
   - Address 0x104 is reissued after the rty.
   - Word 5 is written as 0; total writes 8.
5. Second frame_start during the frame.
   - overrun=1 and stays 1.
   - Frame completes with exactly 8 words.
   - A following frame_start in IDLE restarts at 0x100.
6. Assert sys_rst during READ with ack pending.
   - All outputs are at reset values immediately.
   - No fifo_write occurs.
   - A fresh frame_start yields a full 8-word frame.
